lab3_lut: RTL and testbench

Parametrised, programmable successor to the fixed gate-level logic functions of lab2. Evaluates N_OUT arbitrary Boolean functions of N_IN inputs from a truth table that is loaded serially at run time. Operand stream uses valid/ready handshakes through a 2-stage registered pipeline. Sits in the lab datapath wherever a combinational function block was previously hard-wired.

---
 rtl/lab3_pkg.sv | 19 +
 rtl/lab3_lut_pipe.sv | 69 ++++++
 rtl/lab3_lut.sv | 76 +++++++
 tb/tb_lab3_lut.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_pkg.sv
// Shared types and sizing helpers for the programmable truth-table block.
package lab3_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

  function automatic int tbl_bits(input int n_in, input int n_out);
    return n_out * (1 << n_in);
  endfunction

  // Width of the serial-load bit index; TBL is at least 2, so this is at least 1.
  function automatic int cnt_bits(input int n_in, input int n_out);
    return $clog2(tbl_bits(n_in, n_out));
  endfunction

endpackage

// File: rtl/lab3_lut_pipe.sv
// Two-stage valid/ready pipeline: stage 1 holds the operand, stage 2 the looked-up result.
module lab3_lut_pipe
  import lab3_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_flush,
  input  logic                               i_run,
  input  logic [tbl_bits(N_IN, N_OUT)-1:0]   i_tbl,
  input  logic                               i_in_valid,
  output logic                               o_in_ready,
  input  logic [N_IN-1:0]                    i_in_data,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic [N_OUT-1:0]                   o_out_data
);

  localparam int DEPTH = 1 << N_IN;

  logic              r_s1_valid;
  logic [N_IN-1:0]   r_s1_data;
  logic              r_out_valid;
  logic [N_OUT-1:0]  r_out_data;
  logic              w_adv1;
  logic              w_adv2;
  logic [N_OUT-1:0]  w_lookup;
  logic [DEPTH-1:0]  w_rows [N_OUT];

  for (genvar j = 0; j < N_OUT; j++) begin : g_rows
    assign w_rows[j] = i_tbl[j*DEPTH +: DEPTH];
  end

  always_comb begin
    w_lookup = '0;
    for (int j = 0; j < N_OUT; j++) w_lookup[j] = w_rows[j][r_s1_data];
  end

  assign w_adv2      = !r_out_valid || i_out_ready;
  assign w_adv1      = !r_s1_valid || w_adv2;
  assign o_in_ready  = i_run && w_adv1;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

  // A flush drops both stages; out_data keeps its stale value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (i_flush) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) r_out_data <= w_lookup;
      end
      if (w_adv1) begin
        r_s1_valid <= i_in_valid && o_in_ready;
        if (i_in_valid && o_in_ready) r_s1_data <= i_in_data;
      end
    end
  end

endmodule

// File: rtl/lab3_lut.sv
// Programmable truth-table function block: serial table load FSM plus lookup pipeline.
module lab3_lut
  import lab3_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_bit,
  output logic             cfg_done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data
);

  localparam int TBL = tbl_bits(N_IN, N_OUT);
  localparam int KW  = cnt_bits(N_IN, N_OUT);

  state_e          r_state;
  logic [KW-1:0]   r_k;
  logic [TBL-1:0]  r_tbl;
  logic            w_run;

  assign w_run     = (r_state == RUN);
  assign cfg_ready = (r_state == LOAD);
  assign cfg_done  = w_run;

  // cfg_start wins over everything, including a bit offered in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_k     <= '0;
      r_tbl   <= '0;
    end else if (cfg_start) begin
      r_state <= LOAD;
      r_k     <= '0;
      r_tbl   <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (cfg_valid) begin
            r_tbl[r_k] <= cfg_bit;
            if (r_k == KW'(TBL - 1)) r_state <= RUN;
            else                     r_k     <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  lab3_lut_pipe #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (cfg_start),
    .i_run       (w_run),
    .i_tbl       (r_tbl),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data)
  );

endmodule

// File: tb/tb_lab3_lut.sv
// Scoreboard bench for lab3_lut: parity/AND4 table, backpressure, flush and reset cases.
module tb_lab3_lut;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       out_ready = 1'b1;
  logic       cfg_ready, cfg_done, in_ready, out_valid;
  logic [1:0] out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0] d;
    int         acc;
    bit         exact;
  } exp_t;
  exp_t q[$];

  // out1 = AND4, out0 = parity
  logic [31:0] tbl_a = {16'h8000, 16'h6996};
  logic [31:0] tbl_1 = 32'hFFFF_FFFF;

  lab3_lut #(.N_IN(4), .N_OUT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_bit   (cfg_bit),
    .cfg_done  (cfg_done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // Monitor: a transfer happens on the next edge when out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", {30'd0, out_data}, {30'd0, e.d});
        if (e.exact) chk("latency", cyc, e.acc + 2);
        else         chk("latency_min", {31'd0, cyc >= e.acc + 2}, 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] t, input int from, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = t[from + i];
      @(negedge clk);
      if (!cfg_ready) fail_now("cfg_ready_during_load");
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input logic [1:0] e, input bit exact);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{e, cyc, exact});
        tick();
        in_valid = 1'b0;
        return;
      end
    end
    fail_now("operand_accept");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    fail_now("wait_out_valid");
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    tick();
  endtask

  initial begin
    #2;
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 0);
    chk("rst_cfg_done",  {31'd0, cfg_done},  0);
    chk("rst_in_ready",  {31'd0, in_ready},  0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data",  {30'd0, out_data},  0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // EMPTY guard
    in_valid = 1'b1; in_data = 4'h5; cfg_valid = 1'b1; cfg_bit = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("empty_in_ready",  {31'd0, in_ready},  0);
      chk("empty_cfg_ready", {31'd0, cfg_ready}, 0);
      chk("empty_out_valid", {31'd0, out_valid}, 0);
    end
    tick();
    in_valid = 1'b0; cfg_valid = 1'b0;

    // Load + evaluate back-to-back
    pulse_start();
    chk("load_cfg_ready", {31'd0, cfg_ready}, 1);
    send_bits(tbl_a, 0, 31);
    chk("done_before_last", {31'd0, cfg_done}, 0);
    send_bits(tbl_a, 31, 1);
    chk("done_after_last", {31'd0, cfg_done}, 1);
    chk("ready_after_last", {31'd0, cfg_ready}, 0);
    send(4'hB, 2'b01, 1'b1);
    send(4'hF, 2'b10, 1'b1);
    send(4'h0, 2'b00, 1'b1);
    drain();

    // Backpressure
    out_ready = 1'b0;
    fork
      begin
        send(4'h1, 2'b01, 1'b0);
        send(4'h3, 2'b00, 1'b0);
        send(4'h7, 2'b01, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_in_ready",  {31'd0, in_ready},  0);
        chk("bp_held",      q.size(), 2);
        chk("bp_out_valid", {31'd0, out_valid}, 1);
        chk("bp_out_data",  {30'd0, out_data},  2'b01);
        @(negedge clk);
        chk("bp_stable", {29'd0, out_valid, out_data}, 3'b101);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // cfg_start mid-stream with a result waiting
    out_ready = 1'b0;
    send(4'h5, 2'b00, 1'b0);
    wait_ov();
    tick();
    chk("flush_pre_valid", {31'd0, out_valid}, 1);
    pulse_start();
    q.delete();
    chk("flush_out_valid", {31'd0, out_valid}, 0);
    chk("flush_cfg_ready", {31'd0, cfg_ready}, 1);
    chk("flush_cfg_done",  {31'd0, cfg_done},  0);
    out_ready = 1'b1;
    send_bits(tbl_1, 0, 32);
    chk("ones_done", {31'd0, cfg_done}, 1);
    send(4'h5, 2'b11, 1'b1);
    drain();

    // cfg_start in LOAD after 10 bits, with a bit offered alongside it
    pulse_start();
    send_bits(tbl_a, 0, 10);
    cfg_valid = 1'b1; cfg_bit = 1'b1;
    pulse_start();
    cfg_valid = 1'b0;
    send_bits(tbl_a, 0, 31);
    chk("restart_done_early", {31'd0, cfg_done}, 0);
    send_bits(tbl_a, 31, 1);
    chk("restart_done", {31'd0, cfg_done}, 1);
    send(4'hB, 2'b01, 1'b1);
    send(4'hF, 2'b10, 1'b1);
    drain();

    // Async reset during LOAD
    pulse_start();
    send_bits(tbl_a, 0, 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_load_cfg_ready", {31'd0, cfg_ready}, 0);
    chk("arst_load_cfg_done",  {31'd0, cfg_done},  0);
    chk("arst_load_out_data",  {30'd0, out_data},  0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Async reset while streaming
    pulse_start();
    send_bits(tbl_a, 0, 32);
    out_ready = 1'b0;
    send(4'hF, 2'b10, 1'b0);
    wait_ov();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_run_out_valid", {31'd0, out_valid}, 0);
    chk("arst_run_out_data",  {30'd0, out_data},  0);
    chk("arst_run_cfg_done",  {31'd0, cfg_done},  0);
    chk("arst_run_in_ready",  {31'd0, in_ready},  0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 4'hF;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_in_ready",  {31'd0, in_ready},  0);
      chk("post_rst_out_valid", {31'd0, out_valid}, 0);
    end
    tick();
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
